// File: rtl/tt_sweep_capture.sv
// -----------------------------------------------------------------------------
// tt_sweep_capture
//
// Sweep-and-capture stage around a 3-input combinational gate block. A start
// request drives the eight {a,b,c} combinations in ascending order. Each
// vector is held for SETTLE cycles, then the gate output is sampled into an
// 8-bit truth table. At the end of the sweep the table is compared against
// EXP_TT.
//
// Parameters:
//   SETTLE       cycles each vector is held before sampling (1..15)
//   EXP_TT       expected truth table, bit i = output for {a,b,c} == i
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        sweep request, only honoured in IDLE
//   dut_a/b/c    registered drive to the gate block (a = index bit 2)
//   dut_y        gate block output, sampled in SAMPLE (not synchronised)
//   busy         high while a sweep is in progress (APPLY/SAMPLE)
//   done         one-cycle pulse in the DONE cycle
//   pass         truth_table == EXP_TT, valid from done to next accepted start
//   truth_table  captured table
//   mismatch_cnt popcount(truth_table ^ EXP_TT)
//   sweep_cnt    completed sweeps, saturating at 255
//   sticky_fail  set by any failing sweep until reset
//
// Optional feature macro: TT_SWEEP_STICKY_FAIL_EN
//   defined   -> sticky_fail is a flop set on every failing DONE cycle
//   undefined -> sticky_fail is tied to 0
// -----------------------------------------------------------------------------
module tt_sweep_capture #(
  parameter int unsigned SETTLE = 2,
  parameter logic [7:0]  EXP_TT = 8'h14
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       dut_a,
  output logic       dut_b,
  output logic       dut_c,
  input  logic       dut_y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] truth_table,
  output logic [3:0] mismatch_cnt,
  output logic [7:0] sweep_cnt,
  output logic       sticky_fail
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_APPLY  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  // The settle counter counts down SETTLE-1 .. 0, giving SETTLE APPLY cycles.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] drv_q, drv_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [7:0] tt_q, tt_d;
  logic [3:0] mm_q, mm_d;
  logic [7:0] sweep_q, sweep_d;

  // Next-state and next-output logic. Every output is registered, so the
  // DONE-cycle results are computed on the SAMPLE->DONE transition and are
  // therefore visible together with the done pulse.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    drv_d   = drv_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    tt_d    = tt_q;
    mm_d    = mm_q;
    sweep_d = sweep_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_APPLY;
          idx_d   = 3'd0;
          drv_d   = 3'd0;
          cnt_d   = SETTLE_LOAD;
          busy_d  = 1'b1;
          tt_d    = 8'h00;
          pass_d  = 1'b0;
          mm_d    = 4'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_APPLY: begin
        if (cnt_q == 4'd0) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_SAMPLE: begin
        tt_d[idx_q] = dut_y;
        if (idx_q == 3'd7) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          drv_d   = 3'd0;
          pass_d  = (tt_d == EXP_TT);
          mm_d    = popcount8(tt_d ^ EXP_TT);
          sweep_d = (sweep_q == 8'd255) ? 8'd255 : sweep_q + 8'd1;
        end else begin
          state_d = S_APPLY;
          idx_d   = idx_q + 3'd1;
          drv_d   = idx_q + 3'd1;
          cnt_d   = SETTLE_LOAD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        drv_d   = 3'd0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= 3'd0;
      cnt_q   <= 4'd0;
      drv_q   <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      tt_q    <= 8'h00;
      mm_q    <= 4'd0;
      sweep_q <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      drv_q   <= drv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      tt_q    <= tt_d;
      mm_q    <= mm_d;
      sweep_q <= sweep_d;
    end
  end

`ifdef TT_SWEEP_STICKY_FAIL_EN
  logic sticky_q;
  logic sticky_set_s;

  // A failing sweep is one whose DONE cycle presents pass == 0.
  assign sticky_set_s = done_d & ~pass_d;

  // Sticky failure flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else if (sticky_set_s) begin
      sticky_q <= 1'b1;
    end else begin
      sticky_q <= sticky_q;
    end
  end

  assign sticky_fail = sticky_q;
`else
  assign sticky_fail = 1'b0;
`endif

  assign dut_a        = drv_q[2];
  assign dut_b        = drv_q[1];
  assign dut_c        = drv_q[0];
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign truth_table  = tt_q;
  assign mismatch_cnt = mm_q;
  assign sweep_cnt    = sweep_q;

endmodule

// File: tb/tb_tt_sweep_capture.sv
module tb_tt_sweep_capture;

  logic clk;
  logic rst_n;

  // DUT0: SETTLE=2, gate model optionally stuck-at-1
  logic       start0, stuck0;
  logic       a0, b0, c0, y0, busy0, done0, pass0, sticky0;
  logic [7:0] tt0, cnt0;
  logic [3:0] mm0;

  // DUT1: SETTLE=1, correct gate model, used for held-start test
  logic       start1;
  logic       a1, b1, c1, y1, busy1, done1, pass1, sticky1;
  logic [7:0] tt1, cnt1;
  logic [3:0] mm1;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int dones0  = 0;
  int dones1  = 0;
  int acc1    = 0;

  logic [7:0] exp_cnt    = 8'd0;
  logic       exp_sticky = 1'b0;

  typedef struct packed {
    logic [31:0] done_cyc;
    logic [7:0]  tt;
    logic        pass;
    logic [3:0]  mm;
    logic [7:0]  cnt;
    logic        sticky;
  } exp_t;

  exp_t sb[$];
  logic [2:0] seq1[$];

  // Gate block: y = 1 only at abc = 100 and 010.
  assign y0 = stuck0 | ({a0, b0, c0} == 3'b100) | ({a0, b0, c0} == 3'b010);
  assign y1 = ({a1, b1, c1} == 3'b100) | ({a1, b1, c1} == 3'b010);

  tt_sweep_capture #(.SETTLE(2), .EXP_TT(8'h14)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0),
    .dut_a(a0), .dut_b(b0), .dut_c(c0), .dut_y(y0),
    .busy(busy0), .done(done0), .pass(pass0), .truth_table(tt0),
    .mismatch_cnt(mm0), .sweep_cnt(cnt0), .sticky_fail(sticky0)
  );

  tt_sweep_capture #(.SETTLE(1), .EXP_TT(8'h14)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .dut_a(a1), .dut_b(b1), .dut_c(c1), .dut_y(y1),
    .busy(busy1), .done(done1), .pass(pass1), .truth_table(tt1),
    .mismatch_cnt(mm1), .sweep_cnt(cnt1), .sticky_fail(sticky1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Scoreboard monitor for DUT0: pops an expectation for every done pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done0 === 1'b1) begin
        dones0++;
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done0: got done=1 expected no pending sweep at cycle %0d", cyc);
        end else begin
          e = sb.pop_front();
          check("done0_cycle", 32'(cyc), e.done_cyc);
          check("truth_table0", 32'(tt0), 32'(e.tt));
          check("pass0", 32'(pass0), 32'(e.pass));
          check("mismatch_cnt0", 32'(mm0), 32'(e.mm));
          check("sweep_cnt0", 32'(cnt0), 32'(e.cnt));
          check("sticky_fail0", 32'(sticky0), 32'(e.sticky));
        end
      end
    end
  end

  // Monitor for DUT1: drive sequence while busy, done timing, table.
  initial begin
    logic ok;
    forever begin
      @(negedge clk);
      if (busy1 === 1'b1) seq1.push_back({a1, b1, c1});
      if (done1 === 1'b1) begin
        ok = (seq1.size() == 16);
        for (int j = 0; j < seq1.size(); j++) begin
          if (seq1[j] != 3'(j / 2)) ok = 1'b0;
        end
        check("drive_seq1", 32'(ok), 32'd1);
        check("done1_edge", 32'(cyc - acc1), 32'(16 + 18 * dones1));
        check("truth_table1", 32'(tt1), 32'h14);
        check("pass1", 32'(pass1), 32'd1);
        seq1.delete();
        dones1++;
      end
    end
  end

  task automatic do_sweep(input logic stuck, input logic inject);
    exp_t e;
    int d0;
    int k;
    @(negedge clk);
    stuck0 = stuck;
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    check("busy_after_accept", 32'(busy0), 32'd1);
    exp_cnt = (exp_cnt == 8'd255) ? 8'd255 : exp_cnt + 8'd1;
`ifdef TT_SWEEP_STICKY_FAIL_EN
    if (stuck) exp_sticky = 1'b1;
`endif
    e.done_cyc = 32'(cyc + 24);
    e.tt       = stuck ? 8'hFF : 8'h14;
    e.pass     = ~stuck;
    e.mm       = stuck ? 4'd6 : 4'd0;
    e.cnt      = exp_cnt;
    e.sticky   = exp_sticky;
    sb.push_back(e);
    d0 = dones0;
    if (inject) begin
      repeat (4) @(negedge clk);
      start0 = 1'b1;            // seen by the edge evaluating APPLY
      @(negedge clk);
      start0 = 1'b0;
      @(negedge clk);
      start0 = 1'b1;            // seen by the edge evaluating SAMPLE
      @(negedge clk);
      start0 = 1'b0;
    end
    k = 0;
    while (dones0 == d0 && k < 60) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (dones0 == d0) begin
      n_tests++;
      n_fail++;
      $display("FAIL done0_timeout: got no done expected done within 60 cycles");
    end
    repeat (3) @(negedge clk);
    check("idle_after_sweep", 32'(busy0), 32'd0);
    check("single_done", 32'(dones0 - d0), 32'd1);
  endtask

  initial begin
    rst_n  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    stuck0 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs0", 32'({a0, b0, c0, busy0, done0, pass0, tt0, mm0, cnt0, sticky0}), 32'd0);
    check("reset_outputs1", 32'({a1, b1, c1, busy1, done1, pass1, tt1, mm1, cnt1, sticky1}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_outputs0", 32'({a0, b0, c0, busy0, done0, tt0, cnt0}), 32'd0);

    // Held start on DUT1 (SETTLE=1): accepts at 0,18,36,54,72,90.
    start1 = 1'b1;
    @(posedge clk);
    #1;
    acc1 = cyc;
    check("busy1_after_accept", 32'(busy1), 32'd1);
    repeat (99) @(negedge clk);
    start1 = 1'b0;
    repeat (30) @(negedge clk);
    check("held_done_count1", 32'(dones1), 32'd6);
    check("held_sweep_cnt1", 32'(cnt1), 32'd6);

    // DUT0: correct, stuck-at-1, correct with injected starts.
    do_sweep(1'b0, 1'b0);
    do_sweep(1'b1, 1'b0);
    do_sweep(1'b0, 1'b1);

    // Reset during SAMPLE of idx=4.
    @(negedge clk);
    stuck0 = 1'b0;
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    check("idx4_drive", 32'({a0, b0, c0, busy0}), 32'b1001);
    rst_n = 1'b0;
    #1;
    check("midsweep_reset0", 32'({a0, b0, c0, busy0, done0, pass0, tt0, mm0, cnt0, sticky0}), 32'd0);
    exp_cnt    = 8'd0;
    exp_sticky = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_sweep(1'b0, 1'b0);

    // Saturation: 256 more sweeps, total 257.
    for (int s = 0; s < 256; s++) begin
      do_sweep(1'b0, 1'b0);
    end
    check("sweep_cnt_saturated", 32'(cnt0), 32'd255);
    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
